// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - load/scan signal bundle for the multiplexed 7-segment controller
interface seven_seg_scan_ctrl_if #(
    parameter int N_DIGITS = 4
);
    logic                  en;
    logic                  load_valid;
    logic [4*N_DIGITS-1:0] load_value;
    logic                  load_ready;
    logic                  lz_en;
    logic                  err_clr;
    logic [3:0]            bcd_out;
    logic [N_DIGITS-1:0]   an_n;
    logic                  err;

    modport master (
        output en, load_valid, load_value, lz_en, err_clr,
        input  load_ready, bcd_out, an_n, err
    );

    modport slave (
        input  en, load_valid, load_value, lz_en, err_clr,
        output load_ready, bcd_out, an_n, err
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed BCD digit scanner with guard gaps and frame-aligned updates
module seven_seg_scan_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int DWELL    = 1000,
    parameter int GUARD    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seven_seg_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2((DWELL > GUARD) ? DWELL : GUARD);
    localparam int IW = $clog2(N_DIGITS);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_GUARD} state_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [4*N_DIGITS-1:0] disp, disp_nxt;
    logic [4*N_DIGITS-1:0] shadow, shadow_nxt;
    logic                  pending, pending_nxt;
    logic                  err_q, err_nxt;
    logic                  commit;
    logic                  take;
    logic                  shadow_bad;
    logic                  lz_run;
    logic [N_DIGITS-1:0]   lz_blank;
    logic [3:0]            nib;
    logic [3:0]            code;
    logic [N_DIGITS-1:0]   an_n_q;
    logic [3:0]            bcd_q;

    // Scan sequencing: dwell on a digit, blank for the guard gap, advance; commit only at frame wrap or in IDLE
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                commit = pending;
                if (bus.en) begin
                    state_nxt = ST_SCAN;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            ST_SCAN: begin
                if (cnt == CW'(DWELL - 1)) begin
                    state_nxt = ST_GUARD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt == CW'(GUARD - 1)) begin
                    state_nxt = ST_SCAN;
                    cnt_nxt   = '0;
                    if (idx == IW'(N_DIGITS - 1)) begin
                        idx_nxt = '0;
                        commit  = pending;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!bus.en) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end
    end

    // Load handshake into the shadow register; err is sticky and a new set beats a clear
    always_comb begin
        take        = bus.load_valid & ~pending;
        shadow_nxt  = take ? bus.load_value : shadow;
        pending_nxt = take | (pending & ~commit);
        disp_nxt    = commit ? shadow : disp;
        shadow_bad  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (shadow[4*i +: 4] > 4'd9) shadow_bad = 1'b1;
        end
        err_nxt = (commit & shadow_bad) | (err_q & ~bus.err_clr);
    end

    // Effective code of the digit about to be driven: invalid nibbles and suppressed leading zeros blank
    always_comb begin
        lz_run   = 1'b1;
        lz_blank = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            lz_run      = lz_run & (disp_nxt[4*i +: 4] == 4'd0);
            lz_blank[i] = lz_run;
        end
        nib = disp_nxt[4*idx_nxt +: 4];
        if (nib > 4'd9)
            code = 4'hF;
        else if (bus.lz_en && (idx_nxt != '0) && lz_blank[idx_nxt])
            code = 4'hF;
        else
            code = nib;
    end

    // State, counters and display data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            cnt     <= '0;
            disp    <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            disp    <= disp_nxt;
            shadow  <= shadow_nxt;
            pending <= pending_nxt;
            err_q   <= err_nxt;
        end
    end

    // Registered pad outputs so the anode and segment lines switch together, glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n_q <= '1;
            bcd_q  <= 4'hF;
        end else if (state_nxt == ST_SCAN) begin
            an_n_q <= ~(N_DIGITS'(1) << idx_nxt);
            bcd_q  <= code;
        end else begin
            an_n_q <= '1;
            bcd_q  <= 4'hF;
        end
    end

    assign bus.load_ready = ~pending;
    assign bus.err        = err_q;
    assign bus.an_n       = an_n_q;
    assign bus.bcd_out    = bcd_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - scoreboard bench for the 7-segment scan controller
module tb_seven_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int DW = 4;
    localparam int GD = 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;

    seven_seg_scan_ctrl_if #(.N_DIGITS(ND)) bus ();

    seven_seg_scan_ctrl #(.N_DIGITS(ND), .DWELL(DW), .GUARD(GD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle a digit is lit, pop the next expected {an_n, bcd_out}
    always @(negedge clk) begin
        if (rst_n && bus.an_n != 4'hF && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (bus.an_n !== mon_e[7:4] || bus.bcd_out !== mon_e[3:0]) begin
                errors++;
                $display("FAIL scan_out: an_n=%b bcd=%h expected an_n=%b bcd=%h",
                         bus.an_n, bus.bcd_out, mon_e[7:4], mon_e[3:0]);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_digits(input logic [15:0] codes, input int ndig);
        logic [3:0] an;
        for (int i = 0; i < ndig; i++) begin
            an = ~(4'b0001 << i);
            for (int k = 0; k < DW; k++) exp_q.push_back({an, codes[4*i +: 4]});
        end
    endtask

    task automatic wait_an(input logic [3:0] pat, input string nm);
        int n;
        n = 0;
        while (bus.an_n !== pat && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_reach"}, {28'd0, bus.an_n}, {28'd0, pat});
    endtask

    task automatic load_idle(input logic [15:0] v, input string nm);
        bus.load_valid = 1'b1;
        bus.load_value = v;
        @(negedge clk);
        bus.load_valid = 1'b0;
        chk({nm, "_rdy_lo"}, {31'd0, bus.load_ready}, 32'd0);
        @(negedge clk);
        chk({nm, "_rdy_hi"}, {31'd0, bus.load_ready}, 32'd1);
    endtask

    task automatic run_frames(input int cycles, input string nm);
        bus.en = 1'b1;
        repeat (cycles) @(negedge clk);
        bus.en = 1'b0;
        repeat (5) @(negedge clk);
        chk({nm, "_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        logic [3:0] prev;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_value = '0;
        bus.lz_en = 1'b0;
        bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an_n", {28'd0, bus.an_n}, 32'hF);
        chk("rst_bcd", {28'd0, bus.bcd_out}, 32'hF);
        chk("rst_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_an_n", {28'd0, bus.an_n}, 32'hF);

        // Continuous scan of an all-zero display, plus frame period
        push_digits(16'h0000, 4);
        push_digits(16'h0000, 4);
        bus.en = 1'b1;
        @(negedge clk);
        wait_an(4'b1110, "first_d0");
        prev = bus.an_n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (bus.an_n == 4'b1110 && prev != 4'b1110) break;
            prev = bus.an_n;
        end
        chk("frame_period", n, 32'd20);
        run_frames(22, "zero");

        // Load in IDLE commits immediately
        load_idle(16'h1234, "ld1234");
        push_digits(16'h1234, 4);
        run_frames(24, "f1234");

        // Load mid-frame: old frame finishes, held valid while busy is ignored
        bus.lz_en = 1'b1;
        push_digits(16'h1234, 4);
        push_digits(16'hFF56, 4);
        bus.en = 1'b1;
        @(negedge clk);
        wait_an(4'b1101, "mid_d1");
        bus.load_valid = 1'b1;
        bus.load_value = 16'h0056;
        @(negedge clk);
        bus.load_value = 16'h9999;
        chk("mid_rdy_lo", {31'd0, bus.load_ready}, 32'd0);
        repeat (3) @(negedge clk);
        bus.load_valid = 1'b0;
        wait_an(4'b0111, "mid_d3");
        chk("mid_rdy_d3", {31'd0, bus.load_ready}, 32'd0);
        wait_an(4'b1110, "mid_wrap");
        chk("mid_rdy_wrap", {31'd0, bus.load_ready}, 32'd1);
        repeat (22) @(negedge clk);
        bus.en = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_drained", exp_q.size(), 32'd0);
        bus.lz_en = 1'b0;
        push_digits(16'h0056, 4);
        run_frames(24, "f0056_nolz");

        // Invalid nibble sets err; clear; set and clear together keeps err
        bus.lz_en = 1'b1;
        load_idle(16'h00A0, "ld00A0");
        chk("err_set", {31'd0, bus.err}, 32'd1);
        push_digits(16'hFFF0, 4);
        run_frames(24, "f00A0");
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_cleared", {31'd0, bus.err}, 32'd0);
        bus.load_valid = 1'b1;
        bus.load_value = 16'h000B;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_set_wins", {31'd0, bus.err}, 32'd1);

        // Drop en in GUARD after digit 2, then restart from digit 0
        bus.lz_en = 1'b0;
        load_idle(16'h5678, "ld5678");
        push_digits(16'h5678, 3);
        bus.en = 1'b1;
        @(negedge clk);
        wait_an(4'b1011, "drop_d2");
        wait_an(4'b1111, "drop_guard");
        bus.en = 1'b0;
        @(negedge clk);
        chk("drop_idle_an", {28'd0, bus.an_n}, 32'hF);
        chk("drop_idle_bcd", {28'd0, bus.bcd_out}, 32'hF);
        repeat (3) @(negedge clk);
        chk("drop_drained", exp_q.size(), 32'd0);
        push_digits(16'h5678, 4);
        bus.en = 1'b1;
        repeat (20) @(negedge clk);
        chk("restart_drained", exp_q.size(), 32'd0);

        // Asynchronous reset mid-scan with a pending load discards it
        wait_an(4'b1101, "rst_d1");
        bus.load_valid = 1'b1;
        bus.load_value = 16'h1111;
        @(negedge clk);
        bus.load_valid = 1'b0;
        chk("rst_pend_rdy", {31'd0, bus.load_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        bus.en = 1'b0;
        #1;
        chk("arst_an_n", {28'd0, bus.an_n}, 32'hF);
        chk("arst_bcd", {28'd0, bus.bcd_out}, 32'hF);
        chk("arst_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("arst_err", {31'd0, bus.err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.load_ready}, 32'd1);
        push_digits(16'h0000, 4);
        run_frames(24, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 Parameter DWELL, default 1000: cycles each digit is driven, at least 2.
REQ-003 Parameter GUARD, default 2: all-off cycles between digits (anti-ghosting), at least 1.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-005 en in 1: scan enable.
REQ-006 load_valid in 1: new display value offered.
REQ-007 load_value in 4*N_DIGITS: packed BCD; nibble i is digit i, digit 0 least significant.
REQ-008 load_ready out 1: block can accept a new value.
REQ-009 lz_en in 1: leading-zero suppression enable.
REQ-010 err_clr in 1: clears err.
REQ-011 bcd_out out 4: code driven to the shared BCD-to-7-segment decoder; 4'hF means blank.
REQ-012 an_n out N_DIGITS: digit enables, active-low, one-cold while scanning.
REQ-013 err out 1: sticky flag, set when an invalid nibble is committed.

Function
REQ-014 The FSM SHALL have three states: IDLE, SCAN and GUARD. It also holds digit_idx, a cycle counter cnt, disp (the committed value), shadow, and pending.
REQ-015 IDLE: an_n all 1s and bcd_out 4'hF; when en=1, go to SCAN next cycle with digit_idx=0 and cnt=0.
REQ-016 SCAN: an_n[digit_idx]=0 and all other bits 1; bcd_out is the effective code of digit digit_idx; cnt increments each cycle.
REQ-017 SCAN exit: when cnt==DWELL-1, go to GUARD with cnt=0.
REQ-018 GUARD: an_n all 1s and bcd_out 4'hF for exactly GUARD cycles.
REQ-019 GUARD exit: go to SCAN with digit_idx+1, wrapping from N_DIGITS-1 to 0, and cnt=0.
REQ-020 Frame period SHALL be N_DIGITS*(DWELL+GUARD) cycles.
REQ-021 Outputs an_n and bcd_out SHALL be registered, with one cycle of latency from the state or counter decision.
REQ-022 en=0 in any state SHALL force IDLE on the next cycle, with digit_idx=0 and cnt=0.
REQ-023 Load handshake: a transfer occurs when load_valid=1 and load_ready=1 at a clock edge. On transfer: shadow <= load_value, pending <= 1, and load_ready is 0 from the next cycle.
REQ-024 Commit timing: disp <= shadow on the GUARD-to-SCAN transition where digit_idx wraps to 0, or on the first cycle in IDLE with pending=1. On commit, pending <= 0 and load_ready is 1 from the next cycle.
REQ-025 No mid-frame update SHALL be visible: all digits of one frame show the same disp.
REQ-026 Effective code, invalid digit: a disp nibble > 9 SHALL be shown as 4'hF.
REQ-027 Effective code, leading zeros: with lz_en=1, digit i (i>0) SHALL be shown as 4'hF when it and all higher digits are 0; digit 0 is never suppressed.
REQ-028 Effective code, otherwise: the disp nibble is shown unchanged.
REQ-029 lz_en and the invalid-digit check SHALL be evaluated combinationally on disp, so they take effect at the next registered output.
REQ-030 err SHALL be set on any commit in which some shadow nibble is > 9.
REQ-031 err_clr SHALL clear err; if set and clear occur in the same cycle, set wins.
REQ-032 A load offered while load_ready=0 SHALL be ignored; load_valid may be held.

Reset
REQ-033 While rst_n=0, independent of clk, the block SHALL hold: state IDLE, digit_idx 0, cnt 0, an_n all 1s, bcd_out 4'hF.
REQ-034 While rst_n=0, the block SHALL also hold: disp 0, shadow 0, pending 0, load_ready 1, err 0.
REQ-035 Reset asserted mid-frame or mid-handshake SHALL discard pending data with no commit.
REQ-036 After release, the first SCAN cycle SHALL follow the first edge that samples en=1.

Verification (N_DIGITS=4, DWELL=4, GUARD=1)
REQ-037 Reset, then hold en=1 -> an_n sequence 1110 x4, 1111, 1101 x4, 1111, 1011 x4, 1111, 0111 x4, 1111, then repeats; period 20 cycles; bcd_out=0 on each active digit.
REQ-038 Load 16'h1234 while in IDLE -> commit while in IDLE. After en=1, bcd_out sequence is 4,3,2,1 on digits 0..3; load_ready is low for exactly one commit cycle window.
REQ-039 Load 16'h0056 during digit 1 SCAN -> the current frame still shows the old value; load_ready=0 until the wrap. With lz_en=1 the next frame shows 6,5,F,F; with lz_en=0 it shows 6,5,0,0.
REQ-040 Load 16'h00A0 -> err=1 after commit; digit 1 shows 4'hF. Assert err_clr and another invalid commit in the same cycle -> err stays 1.
REQ-041 Drop en during GUARD of digit 2 -> IDLE next cycle with an_n=1111. Re-raise en -> scan restarts at digit 0.
REQ-042 Assert rst_n=0 asynchronously mid-SCAN with pending=1 -> outputs go to reset values immediately; after release, disp=0 and load_ready=1.
